// File: rtl/fir_pkg.sv
// fir_pkg: shared parameters, FSM state type and saturation limits for the FIR MAC engine
package fir_pkg;
  localparam int NTAPS  = 64;
  localparam int DATA_W = 16;
  localparam int FRAC   = 15;
  localparam int TAP_AW = 6;
  localparam int ACC_W  = 2 * DATA_W + TAP_AW;
  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, MAC, DONE} state_e;
endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: round-half-up the Q.15 accumulator and saturate it to a signed DATA_W sample
module fir_round_sat
  import fir_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] y_o
);
  localparam int RW = ACC_W - FRAC;
  logic signed [ACC_W-1:0] rnd;
  logic signed [RW-1:0]    shf;
  always_comb begin
    rnd = acc_i + (ACC_W'(1) << (FRAC - 1));
    shf = rnd[ACC_W-1:FRAC];
    y_o = (shf > RW'(SAT_MAX)) ? SAT_MAX : (shf < RW'(SAT_MIN)) ? SAT_MIN : shf[DATA_W-1:0];
  end
endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: sequential 64-tap FIR, one MAC per cycle, one rounded/saturated output per FIFO sample
module fir_mac_engine
  import fir_pkg::*;
(
  input  logic              clk2,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  input  logic              coef_we,
  input  logic [TAP_AW-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              busy,
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid
);
  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         delay_q [NTAPS];
  logic [DATA_W-1:0]         coef_q  [NTAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_nx;
  logic [TAP_AW-1:0]         wr_ptr_q, tap_q, rd_idx;
  logic [DATA_W-1:0]         y_out_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]  y_nx;
  // newest sample sits at wr_ptr; older ones walk backwards modulo 64
  always_comb begin
    rd_idx = wr_ptr_q - tap_q;
    prod   = $signed(delay_q[rd_idx]) * $signed(coef_q[tap_q]);
    acc_nx = acc_q + ACC_W'(prod);
  end
  fir_round_sat u_round_sat (.acc_i(acc_nx), .y_o(y_nx));
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fifo_empty ? IDLE : READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = MAC;
      MAC:     state_d = (tap_q == TAP_AW'(NTAPS - 1)) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    fifo_r_en = state_q == READ;
    busy      = state_q != IDLE;
    y_valid   = state_q == DONE;
    y_out     = y_out_q;
  end
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
      acc_q    <= '0;
      wr_ptr_q <= '0;
      tap_q    <= '0;
      y_out_q  <= '0;
    end else begin
      if (state_q == IDLE && coef_we) coef_q[coef_addr] <= coef_data;
      if (state_q == CAPTURE) begin
        delay_q[wr_ptr_q] <= fifo_data;
        acc_q <= '0;
        tap_q <= '0;
      end
      if (state_q == MAC) begin
        acc_q <= acc_nx;
        tap_q <= tap_q + 1'b1;
        if (tap_q == TAP_AW'(NTAPS - 1)) y_out_q <= y_nx;
      end
      if (state_q == DONE) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end
endmodule
